// File: rtl/ram_latency_ctrl.sv
// ram_latency_ctrl: word-addressed RAM model with a programmable access latency.
// Requests are held by the master until ACCESS. ramstate and ramload are
// combinational from the registered state, the counter and the live inputs.
module ram_latency_ctrl #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 16384
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  localparam int unsigned CNT_W = $clog2(LAT) + 1;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_FREE   = 2'b00;
  localparam logic [1:0] ST_BUSY   = 2'b01;
  localparam logic [1:0] ST_ACCESS = 2'b10;
  localparam logic [1:0] ST_ERROR  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic               ren_q, ren_d;
  logic               wen_q, wen_d;

  logic [31:0]        mem [DEPTH];

  logic               any_en_c;
  logic               err_c;
  logic               req_c;
  logic               match_c;
  logic               we_c;
  logic [AW-1:0]      idx_c;

  // Classify the live request: error has priority over any valid access.
  always_comb begin
    any_en_c = ramREN | ramWEN;
    err_c    = any_en_c &&
               ((ramREN && ramWEN) ||
                (ramaddr[1:0] != 2'b00) ||
                ({2'b00, ramaddr[31:2]} >= 32'(DEPTH)));
    req_c    = any_en_c && !err_c;
    match_c  = (ramaddr == addr_q) && (ramREN == ren_q) && (ramWEN == wen_q);
    idx_c    = ramaddr[AW+1:2];
  end

  // Next-state, latency counter and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    ramstate = ST_FREE;
    ramload  = 32'h0;
    we_c     = 1'b0;
    if (RST) begin
      // Outputs forced quiet while reset is held; flops are cleared async.
      ramstate = ST_FREE;
    end else if (err_c) begin
      ramstate = ST_ERROR;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_c) begin
            ramstate = ST_BUSY;
            addr_d   = ramaddr;
            ren_d    = ramREN;
            wen_d    = ramWEN;
            cnt_d    = CNT_W'(LAT - 1);
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (!req_c) begin
            // Master gave up: abandon without touching memory.
            state_d = IDLE;
          end else if (!match_c) begin
            // Request changed mid-flight: restart latency for the new one.
            ramstate = ST_BUSY;
            addr_d   = ramaddr;
            ren_d    = ramREN;
            wen_d    = ramWEN;
            cnt_d    = CNT_W'(LAT - 1);
          end else if (cnt_q != '0) begin
            ramstate = ST_BUSY;
            cnt_d    = cnt_q - CNT_W'(1);
          end else begin
            ramstate = ST_ACCESS;
            if (ren_q) begin
              ramload = mem[idx_c];
            end
            we_c    = wen_q;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= 32'h0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
    end
  end

  // Storage array: not reset, written only in a write ACCESS cycle.
  always_ff @(posedge CLK) begin
    if (we_c) begin
      mem[idx_c] <= ramstore;
    end
  end

endmodule

// File: tb/tb_ram_latency_ctrl.sv
// Bench for ram_latency_ctrl: three instances (LAT=1,2,3) driven by directed
// vectors; each cycle's expected ramstate/ramload is queued by the stimulus and
// checked by an independent negedge monitor.
module tb_ram_latency_ctrl;

  localparam logic [1:0] FREE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] ACC  = 2'b10;
  localparam logic [1:0] ERR  = 2'b11;

  typedef struct {
    int          inst;
    logic [1:0]  st;
    logic [31:0] ld;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ren   [3];
  logic        wen   [3];
  logic [31:0] addr  [3];
  logic [31:0] store [3];
  logic [31:0] load  [3];
  logic [1:0]  st    [3];

  exp_t exp_q [$];
  int   checks;
  int   errors;

  ram_latency_ctrl #(.LAT(1), .DEPTH(16384)) u_l1 (
    .CLK(clk), .RST(rst), .ramREN(ren[0]), .ramWEN(wen[0]),
    .ramaddr(addr[0]), .ramstore(store[0]), .ramload(load[0]), .ramstate(st[0])
  );
  ram_latency_ctrl #(.LAT(2), .DEPTH(16384)) u_l2 (
    .CLK(clk), .RST(rst), .ramREN(ren[1]), .ramWEN(wen[1]),
    .ramaddr(addr[1]), .ramstore(store[1]), .ramload(load[1]), .ramstate(st[1])
  );
  ram_latency_ctrl #(.LAT(3), .DEPTH(16384)) u_l3 (
    .CLK(clk), .RST(rst), .ramREN(ren[2]), .ramWEN(wen[2]),
    .ramaddr(addr[2]), .ramstore(store[2]), .ramload(load[2]), .ramstate(st[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus on instance i and queue its expected response.
  task automatic step(input int i, input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] es, input logic [31:0] el, input string nm);
    exp_t e;
    ren[i]   = r;
    wen[i]   = w;
    addr[i]  = a;
    store[i] = d;
    e.inst = i;
    e.st   = es;
    e.ld   = el;
    e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int i, input string nm);
    step(i, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, nm);
  endtask

  // Monitor: compares every queued expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, "_state"}, 32'(st[e.inst]), 32'(e.st));
      check({e.name, "_load"}, load[e.inst], e.ld);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ren[i] = 1'b0; wen[i] = 1'b0; addr[i] = 32'h0; store[i] = 32'h0;
    end
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_state%0d", i), 32'(st[i]), 32'(FREE));
      check($sformatf("reset_load%0d", i), load[i], 32'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // LAT=2: write then read back 0x40.
    step(1, 0, 1, 32'h40, 32'hDEADBEEF, BUSY, 32'h0, "l2_wr40_c0");
    step(1, 0, 1, 32'h40, 32'hDEADBEEF, BUSY, 32'h0, "l2_wr40_c1");
    step(1, 0, 1, 32'h40, 32'hDEADBEEF, ACC,  32'h0, "l2_wr40_c2");
    step(1, 1, 0, 32'h40, 32'h0, BUSY, 32'h0,        "l2_rd40_c0");
    step(1, 1, 0, 32'h40, 32'h0, BUSY, 32'h0,        "l2_rd40_c1");
    step(1, 1, 0, 32'h40, 32'h0, ACC,  32'hDEADBEEF, "l2_rd40_c2");
    idle(1, "l2_idle0");

    // LAT=1: preload 0x0, read it, then a held read is serviced twice.
    step(0, 0, 1, 32'h0, 32'h12345678, BUSY, 32'h0, "l1_wr0_c0");
    step(0, 0, 1, 32'h0, 32'h12345678, ACC,  32'h0, "l1_wr0_c1");
    idle(0, "l1_idle0");
    step(0, 1, 0, 32'h0, 32'h0, BUSY, 32'h0,         "l1_rd0_c0");
    step(0, 1, 0, 32'h0, 32'h0, ACC,  32'h12345678,  "l1_rd0_c1");
    idle(0, "l1_idle1");
    step(0, 1, 0, 32'h0, 32'h0, BUSY, 32'h0,         "l1_hold_c0");
    step(0, 1, 0, 32'h0, 32'h0, ACC,  32'h12345678,  "l1_hold_c1");
    step(0, 1, 0, 32'h0, 32'h0, BUSY, 32'h0,         "l1_hold_c2");
    step(0, 1, 0, 32'h0, 32'h0, ACC,  32'h12345678,  "l1_hold_c3");
    idle(0, "l1_idle2");

    // LAT=3: preload words 2 and 3, then switch read 0x8 -> 0xC mid-wait.
    for (int k = 0; k < 3; k++) step(2, 0, 1, 32'h8, 32'h22222222, BUSY, 32'h0, "l3_wr8");
    step(2, 0, 1, 32'h8, 32'h22222222, ACC, 32'h0, "l3_wr8_acc");
    for (int k = 0; k < 3; k++) step(2, 0, 1, 32'hC, 32'h33333333, BUSY, 32'h0, "l3_wrC");
    step(2, 0, 1, 32'hC, 32'h33333333, ACC, 32'h0, "l3_wrC_acc");
    idle(2, "l3_idle0");
    step(2, 1, 0, 32'h8, 32'h0, BUSY, 32'h0, "l3_rd8_c0");
    step(2, 1, 0, 32'hC, 32'h0, BUSY, 32'h0, "l3_swC_c0");
    step(2, 1, 0, 32'hC, 32'h0, BUSY, 32'h0, "l3_swC_c1");
    step(2, 1, 0, 32'hC, 32'h0, BUSY, 32'h0, "l3_swC_c2");
    step(2, 1, 0, 32'hC, 32'h0, ACC,  32'h33333333, "l3_swC_c3");
    idle(2, "l3_idle1");

    // LAT=2: dropped write to 0x20 must not commit.
    step(1, 0, 1, 32'h20, 32'h11111111, BUSY, 32'h0, "l2_wr20_c0");
    step(1, 0, 1, 32'h20, 32'h11111111, BUSY, 32'h0, "l2_wr20_c1");
    step(1, 0, 1, 32'h20, 32'h11111111, ACC,  32'h0, "l2_wr20_c2");
    idle(1, "l2_idle1");
    step(1, 0, 1, 32'h20, 32'h99999999, BUSY, 32'h0, "l2_drop_c0");
    idle(1, "l2_drop_free");
    idle(1, "l2_drop_free2");
    step(1, 1, 0, 32'h20, 32'h0, BUSY, 32'h0,        "l2_rd20_c0");
    step(1, 1, 0, 32'h20, 32'h0, BUSY, 32'h0,        "l2_rd20_c1");
    step(1, 1, 0, 32'h20, 32'h0, ACC,  32'h11111111, "l2_rd20_c2");
    idle(1, "l2_idle2");

    // LAT=2: error cases, then a normal read.
    step(1, 1, 1, 32'h40,    32'h0, ERR, 32'h0, "l2_err_both");
    step(1, 1, 0, 32'h2,     32'h0, ERR, 32'h0, "l2_err_misalign");
    step(1, 1, 0, 32'h10000, 32'h0, ERR, 32'h0, "l2_err_range");
    step(1, 1, 0, 32'h40, 32'h0, BUSY, 32'h0,        "l2_rd40b_c0");
    step(1, 1, 0, 32'h40, 32'h0, BUSY, 32'h0,        "l2_rd40b_c1");
    step(1, 1, 0, 32'h40, 32'h0, ACC,  32'hDEADBEEF, "l2_rd40b_c2");
    idle(1, "l2_idle3");

    // LAT=2: error in the middle of a wait abandons it.
    step(1, 1, 0, 32'h40, 32'h0, BUSY, 32'h0, "l2_mid_c0");
    step(1, 1, 0, 32'h2,  32'h0, ERR,  32'h0, "l2_mid_err");
    step(1, 1, 0, 32'h40, 32'h0, BUSY, 32'h0,        "l2_mid_r0");
    step(1, 1, 0, 32'h40, 32'h0, BUSY, 32'h0,        "l2_mid_r1");
    step(1, 1, 0, 32'h40, 32'h0, ACC,  32'hDEADBEEF, "l2_mid_r2");
    idle(1, "l2_idle4");

    // LAT=2: reset pulsed while a write to 0x10 is busy; held write restarts.
    step(1, 0, 1, 32'h10, 32'hCAFEF00D, BUSY, 32'h0, "l2_rst_c0");
    rst = 1'b1;
    #1;
    check("l2_rst_async_state", 32'(st[1]), 32'(FREE));
    check("l2_rst_async_load", load[1], 32'h0);
    begin
      exp_t e;
      e.inst = 1; e.st = FREE; e.ld = 32'h0; e.name = "l2_rst_hold";
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 0, 1, 32'h10, 32'hCAFEF00D, BUSY, 32'h0, "l2_rst_r0");
    step(1, 0, 1, 32'h10, 32'hCAFEF00D, BUSY, 32'h0, "l2_rst_r1");
    step(1, 0, 1, 32'h10, 32'hCAFEF00D, ACC,  32'h0, "l2_rst_r2");
    idle(1, "l2_idle5");
    step(1, 1, 0, 32'h10, 32'h0, BUSY, 32'h0,        "l2_rd10_c0");
    step(1, 1, 0, 32'h10, 32'h0, BUSY, 32'h0,        "l2_rd10_c1");
    step(1, 1, 0, 32'h10, 32'h0, ACC,  32'hCAFEF00D, "l2_rd10_c2");
    idle(1, "l2_idle6");

    if (exp_q.size() != 0) begin
      check("queue_drained", 32'(exp_q.size()), 32'h0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_latency_ctrl.md
# ram_latency_ctrl

Word-addressed RAM model with a programmable access latency, sitting directly downstream of the core's top block on the RAM side of the CPU–RAM interface. It accepts the read/write requests that the memory controller drives out (address, store data, read/write enables). It returns load data plus a 2-bit RAM state that reports free, busy, access-complete, or error. The block lets caches and the coherence controller be exercised against realistic multi-cycle memory.

## Interface
- LAT, 2: access latency in cycles, ≥1; ACCESS is reported LAT cycles after a request is first presented.
- DEPTH, 16384: number of 32-bit words stored; valid word index 0..DEPTH-1.
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- ramREN  in  1  read request, held until ACCESS seen.
- ramWEN  in  1  write request, held until ACCESS seen.
- ramaddr  in  32  byte address; must be word aligned.
- ramstore  in  32  write data, sampled when the write commits.
- ramload  out  32  read data, valid only while ramstate = ACCESS for a read; else 0.
- ramstate  out  2  FREE=2'b00, BUSY=2'b01, ACCESS=2'b10, ERROR=2'b11.

## Operation
- States: IDLE, WAIT. Registers: state, cnt (width $clog2(LAT)+1), captured addr/REN/WEN.
- Request = exactly one of ramREN/ramWEN high, addr[1:0]=0, addr[31:2] < DEPTH.
- Error = ramREN and ramWEN both high, or misaligned, or out of range. This condition has priority over everything else.
- On error: ramstate=ERROR (combinational) in any state. No memory access. Next state IDLE.
- IDLE, no enables: ramstate=FREE, stay IDLE.
- IDLE, valid request: ramstate=BUSY. Capture addr/op. Set cnt=LAT-1. Go to WAIT.
- WAIT, request matches captured (same addr, same op), cnt≠0: ramstate=BUSY, cnt decrements.
- WAIT, match, cnt=0: ramstate=ACCESS.
  - Read: ramload=mem[addr[31:2]].
  - Write: mem[addr[31:2]]←ramstore at the end of this cycle.
  - Next state IDLE.
- WAIT, request changed (different addr or op, still valid): treat it as a new request. ramstate=BUSY. Recapture. cnt=LAT-1. Stay WAIT. No access for the abandoned request.
- WAIT, enables both dropped: go to IDLE, ramstate=FREE, no access. A dropped write never commits.
- A request still held in the cycle after ACCESS is a new request. It is serviced again after a further LAT cycles.
- Memory contents are not cleared by RST. Contents are undefined at power-up.

## Timing
- Reset values: state=IDLE, cnt=0, captured regs=0. With enables low, ramstate=FREE and ramload=0 immediately on RST assertion. These values are independent of CLK.
- Latency: request first high in cycle c0 → BUSY in c0..c0+LAT-1, ACCESS in c0+LAT.
  - LAT=1: BUSY in c0, ACCESS in c1.
- ramstate and ramload are combinational from state/cnt/inputs. They change in the same cycle that the inputs change.
- Read data is combinational from the array in the ACCESS cycle.
- A write is visible to a read presented in the next cycle; that read reaches ACCESS at the earliest LAT cycles later.
- RST asserted mid-WAIT: the pending access is abandoned, with no write commit. After RST deasserts, a held request restarts from IDLE with full latency.
- Error mid-WAIT: ERROR is shown that cycle and the pending access is dropped. A valid request afterwards starts fresh from IDLE.
- Back-to-back requests: IDLE→WAIT→IDLE alternation. Maximum throughput is one access per LAT+1 cycles.

## Test plan
- LAT=2: write 0xDEADBEEF to 0x40 held → BUSY, BUSY, ACCESS. Then read 0x40 → BUSY, BUSY, ACCESS with ramload=0xDEADBEEF.
- LAT=1: read of 0x0 (contents preloaded to 0x12345678) → BUSY in cycle 0, ACCESS in cycle 1 with ramload=0x12345678; next cycle with enables low → FREE, ramload=0.
- LAT=3: read 0x8 for 1 cycle, then switch to read 0xC → counter restarts. ACCESS arrives 3 cycles after the switch with mem[3]. mem[2] is never returned.
- Write to 0x20 with WEN dropped after 1 cycle (LAT=2) → FREE. A subsequent read of 0x20 returns the old value.
- REN and WEN both high, addr 0x2 (misaligned), and addr 4*DEPTH → ERROR each cycle. No state change; the following valid read completes normally.
- RST pulsed during BUSY of a write to 0x10 → ramstate FREE asynchronously. mem[4] is unchanged; the request held after reset completes LAT cycles later.
